// File: rtl/led_matrix_pkg.sv
// Shared constants and FSM state type for the 8x8 LED matrix frame loader.
package led_matrix_pkg;

  localparam int unsigned NLEDS = 64;
  localparam int unsigned ROW_W = 8;
  localparam int unsigned NROWS = 8;
  localparam int unsigned CNT_W = $clog2(NLEDS);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StStrobe,
    StDone
  } state_e;

endpackage

// File: rtl/led_frame_shifter.sv
// Parallel-in/serial-out frame register with shift counter; MSB leaves first.
module led_frame_shifter
  import led_matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NLEDS-1:0] load_data,
  input  logic             shift,
  output logic             ser_bit,
  output logic             last
);

  logic [NLEDS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = '0;
    end else if (shift) begin
      shreg_d = {shreg_q[NLEDS-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_bit = shreg_q[NLEDS-1];
  assign last    = (cnt_q == CNT_W'(NLEDS - 1));

endmodule

// File: rtl/led_frame_loader.sv
// Double-buffered frame loader feeding the LED driver shift chain and latch strobe.
// Define LOADER_AUTO_REFRESH_EN to re-send the last committed frame after an idle period.
module led_frame_loader
  import led_matrix_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
`ifdef LOADER_AUTO_REFRESH_EN
  ,
  parameter logic [23:0] REFRESH_CYCLES = 24'd10_000_000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_row,
  input  logic [ROW_W-1:0] wr_data,
  input  logic             wr_last,
  output logic             ser_data,
  output logic             ser_shift,
  output logic             strobe,
  output logic             busy,
  output logic             frame_done
);

  logic [NROWS-1:0][ROW_W-1:0] staging_q, staging_d;
  logic [NROWS-1:0][ROW_W-1:0] shadow_q, shadow_d;
  logic                        pending_q, pending_d;
  state_e                      state_q, state_d;
  logic [7:0]                  strobe_cnt_q, strobe_cnt_d;

  logic wr_accept, commit;
  logic sh_load, sh_shift, sh_bit, sh_last;
  logic refresh_fire;

  assign wr_ready  = !pending_q;
  assign wr_accept = wr_valid && !pending_q;
  assign commit    = wr_accept && wr_last;

  // Shadow captures staging including the row written on the committing edge.
  always_comb begin
    staging_d = staging_q;
    if (wr_accept) begin
      staging_d[wr_row] = wr_data;
    end
    shadow_d = commit ? staging_d : shadow_q;
  end

  // Commit wins over the clear issued by LOAD on the same edge.
  always_comb begin
    pending_d = pending_q;
    if (state_q == StLoad) begin
      pending_d = 1'b0;
    end
    if (commit) begin
      pending_d = 1'b1;
    end
  end

`ifdef LOADER_AUTO_REFRESH_EN
  logic [23:0] refresh_q, refresh_d;

  assign refresh_fire = (state_q == StIdle) && !pending_q &&
                        (refresh_q == REFRESH_CYCLES - 24'd1);

  always_comb begin
    refresh_d = refresh_q;
    if ((state_q == StLoad) || pending_q || commit) begin
      refresh_d = '0;
    end else if (state_q == StIdle) begin
      refresh_d = refresh_fire ? 24'd0 : refresh_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_d;
    end
  end
`else
  assign refresh_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    strobe_cnt_d = strobe_cnt_q;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_q || refresh_fire) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        sh_load = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        sh_shift     = 1'b1;
        strobe_cnt_d = '0;
        if (sh_last) begin
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        if (strobe_cnt_q == 8'(STROBE_CYCLES - 1)) begin
          state_d = StDone;
        end else begin
          strobe_cnt_d = strobe_cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      staging_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      state_q      <= StIdle;
      strobe_cnt_q <= '0;
    end else begin
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      strobe_cnt_q <= strobe_cnt_d;
    end
  end

  led_frame_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .load_data (shadow_q),
    .shift     (sh_shift),
    .ser_bit   (sh_bit),
    .last      (sh_last)
  );

  assign ser_shift  = (state_q == StShift);
  assign ser_data   = ser_shift & sh_bit;
  assign strobe     = (state_q == StStrobe);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed self-checking bench for led_frame_loader (default build, auto refresh off).
module tb_led_frame_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       wr_last = 1'b0;
  logic       ser_data, ser_shift, strobe, busy, frame_done;

  always #5 clk = ~clk;

  led_frame_loader #(.STROBE_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .ser_data   (ser_data),
    .ser_shift  (ser_shift),
    .strobe     (strobe),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         k;
    logic [2:0] row;
    logic [7:0] data;
    logic       last;
  } wr_t;
  wr_t sched[$];

  logic [63:0] cap[2];
  int nshift[2], first_shift[2], strobe_first[2], nstrobe[2], done_k[2];
  int ndone, tot_shift, tot_strobe, zero_viol, busy_cycles;
  logic ready_hist[400];

  task automatic clear_obs();
    for (int i = 0; i < 2; i++) begin
      cap[i] = '0; nshift[i] = 0; first_shift[i] = -1; strobe_first[i] = -1;
      nstrobe[i] = 0; done_k[i] = -1;
    end
    ndone = 0; tot_shift = 0; tot_strobe = 0; zero_viol = 0; busy_cycles = 0;
  endtask

  // Observe ncyc cycles at negedges; k=0 is the cycle right after the last commit edge.
  task automatic collect(input int ncyc);
    int f;
    clear_obs();
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      f = (ndone < 2) ? ndone : 1;
      if (ser_shift) begin
        if (nshift[f] == 0) first_shift[f] = k;
        cap[f] = {cap[f][62:0], ser_data};
        nshift[f]++;
        tot_shift++;
      end else if (ser_data) begin
        zero_viol++;
      end
      if (strobe) begin
        if (nstrobe[f] == 0) strobe_first[f] = k;
        nstrobe[f]++;
        tot_strobe++;
      end
      if (frame_done) begin
        if (ndone < 2) done_k[ndone] = k;
        ndone++;
      end
      if (busy) busy_cycles++;
      ready_hist[k] = wr_ready;
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      for (int i = 0; i < sched.size(); i++) begin
        if (sched[i].k == k) begin
          wr_valid = 1'b1;
          wr_row   = sched[i].row;
          wr_data  = sched[i].data;
          wr_last  = sched[i].last;
        end
      end
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    sched.delete();
  endtask

  task automatic write_row(input logic [2:0] row, input logic [7:0] data, input logic last);
    int w;
    @(negedge clk);
    wr_valid = 1'b1; wr_row = row; wr_data = data; wr_last = last;
    w = 0;
    while (!wr_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("wr_ready_timeout", 64'(wr_ready), 64'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic write_frame(input logic [63:0] fr, input bit rev);
    int r;
    for (int i = 0; i < 8; i++) begin
      r = rev ? 7 - i : i;
      write_row(3'(r), fr[8*r +: 8], i == 7);
    end
  endtask

  typedef struct {
    logic [7:0][7:0] rows;
    bit              rev;
    logic [63:0]     exp;
  } vec_t;
  vec_t vecs[3];

  initial begin
    vecs[0] = '{rows: {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01},
                rev: 1'b0, exp: 64'h8040201008040201};
    vecs[1] = '{rows: {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00},
                rev: 1'b1, exp: 64'h0706050403020100};
    vecs[2] = '{rows: {8'hF0, 8'h0F, 8'hC3, 8'h3C, 8'hA5, 8'h5A, 8'h81, 8'h7E},
                rev: 1'b0, exp: 64'hF00FC33CA55A817E};

    // Reset held two cycles
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ser_shift", 64'(ser_shift), 64'd0);
    check("rst_strobe", 64'(strobe), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single frames with latency checks
    for (int v = 0; v < 3; v++) begin
      write_frame(vecs[v].rows, vecs[v].rev);
      collect(75);
      check($sformatf("v%0d_frame", v), cap[0], vecs[v].exp);
      check($sformatf("v%0d_nshift", v), 64'(nshift[0]), 64'd64);
      check($sformatf("v%0d_first_shift", v), 64'(first_shift[0]), 64'd2);
      check($sformatf("v%0d_strobe_first", v), 64'(strobe_first[0]), 64'd66);
      check($sformatf("v%0d_nstrobe", v), 64'(nstrobe[0]), 64'd2);
      check($sformatf("v%0d_done_k", v), 64'(done_k[0]), 64'd68);
      check($sformatf("v%0d_ndone", v), 64'(ndone), 64'd1);
      check($sformatf("v%0d_busy_cycles", v), 64'(busy_cycles), 64'd68);
      check($sformatf("v%0d_ser_data_zero", v), 64'(zero_viol), 64'd0);
    end

    // Frame B committed while frame A is shifting
    write_frame(64'h0123456789ABCDEF, 1'b0);
    begin
      logic [63:0] fb;
      fb = 64'hFEDCBA9876543210;
      for (int r = 0; r < 8; r++) begin
        sched.push_back('{k: 10 + r, row: 3'(r), data: fb[8*r +: 8], last: (r == 7)});
      end
    end
    collect(150);
    check("ab_frame_a", cap[0], 64'h0123456789ABCDEF);
    check("ab_frame_b", cap[1], 64'hFEDCBA9876543210);
    check("ab_ndone", 64'(ndone), 64'd2);
    check("ab_nshift_b", 64'(nshift[1]), 64'd64);
    check("ab_ready_after_commit", 64'(ready_hist[18]), 64'd0);
    check("ab_ready_at_a_done", 64'(ready_hist[68]), 64'd0);
    check("ab_ready_at_b_load", 64'(ready_hist[70]), 64'd0);
    check("ab_ready_after_b_load", 64'(ready_hist[71]), 64'd1);
    check("ab_b_first_shift", 64'(first_shift[1]), 64'd71);
    check("ab_b_done_k", 64'(done_k[1]), 64'd137);

    // Reset on the 30th shift cycle aborts the frame
    write_frame(64'hDEADBEEFCAFEF00D, 1'b0);
    begin
      int ns, w;
      ns = 0; w = 0;
      while (ns < 30 && w < 200) begin
        @(negedge clk);
        if (ser_shift) ns++;
        w++;
      end
      check("rst_mid_reached", 64'(ns), 64'd30);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ser_shift", 64'(ser_shift), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_strobe", 64'(strobe), 64'd0);
    check("rst_mid_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    collect(100);
    check("rst_mid_no_strobe", 64'(tot_strobe), 64'd0);
    check("rst_mid_no_shift", 64'(tot_shift), 64'd0);
    check("rst_mid_idle", 64'(busy_cycles), 64'd0);

    // Staging overwrite during SHIFT leaves the active frame intact
    write_frame(64'h1122334455667788, 1'b0);
    sched.push_back('{k: 20, row: 3'd3, data: 8'hFF, last: 1'b0});
    collect(75);
    check("stg_frame_unchanged", cap[0], 64'h1122334455667788);
    check("stg_ndone", 64'(ndone), 64'd1);
    write_row(3'd0, 8'h88, 1'b1);
    collect(75);
    check("stg_next_frame", cap[0], 64'h11223344FF667788);

    // No re-send without auto refresh
    collect(300);
    check("norefresh_shift", 64'(tot_shift), 64'd0);
    check("norefresh_busy", 64'(busy_cycles), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
